// File: rtl/lsab_drain_if.sv
// Signal bundle between the LSAB FIFO block, the drain engine and the downstream consumer.
// The master modport is the drain's view; the slave modport is the LSAB/consumer side.
interface lsab_drain_if;
   logic        EMPTY_0, EMPTY_1, EMPTY_2, EMPTY_3;
   logic        STOP_0, STOP_1, STOP_2, STOP_3;
   logic [31:0] IN;
   logic        READ;
   logic [1:0]  READ_FIFO;
   logic        CAREOF_INT_0, CAREOF_INT_1, CAREOF_INT_2, CAREOF_INT_3;
   logic [3:0]  ENABLE;
   logic [3:0]  INT_ACK;
   logic [3:0]  INT_PENDING;
   logic [31:0] DATA_OUT;
   logic [1:0]  DATA_FIFO;
   logic        DATA_VALID;
   logic        DATA_READY;

   modport master (
      input  EMPTY_0, EMPTY_1, EMPTY_2, EMPTY_3,
      input  STOP_0, STOP_1, STOP_2, STOP_3,
      input  IN, ENABLE, INT_ACK, DATA_READY,
      output READ, READ_FIFO,
      output CAREOF_INT_0, CAREOF_INT_1, CAREOF_INT_2, CAREOF_INT_3,
      output INT_PENDING, DATA_OUT, DATA_FIFO, DATA_VALID
   );

   modport slave (
      output EMPTY_0, EMPTY_1, EMPTY_2, EMPTY_3,
      output STOP_0, STOP_1, STOP_2, STOP_3,
      output IN, ENABLE, INT_ACK, DATA_READY,
      input  READ, READ_FIFO,
      input  CAREOF_INT_0, CAREOF_INT_1, CAREOF_INT_2, CAREOF_INT_3,
      input  INT_PENDING, DATA_OUT, DATA_FIFO, DATA_VALID
   );
endinterface

// File: rtl/lsab_drain.sv
// Round-robin burst drain of the four LSAB FIFOs into one valid/ready word stream,
// plus the per-FIFO interrupt-marker pending/acknowledge handshake.
module lsab_drain #(
   parameter int BURST = 8
) (
   input logic          CLK,
   input logic          RST,
   lsab_drain_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

   localparam logic [3:0] BURST_LIM = 4'(BURST);

   state_t     state;
   logic [1:0] ptr;
   logic [1:0] sel;
   logic [3:0] burst_cnt;
   logic [3:0] empty_vec;
   logic [3:0] stop_vec;
   logic [3:0] eligible;
   logic [3:0] pend;
   logic [3:0] careof;
   logic       found;
   logic [1:0] pick;

   assign empty_vec = {bus.EMPTY_3, bus.EMPTY_2, bus.EMPTY_1, bus.EMPTY_0};
   assign stop_vec  = {bus.STOP_3, bus.STOP_2, bus.STOP_1, bus.STOP_0};
   assign eligible  = bus.ENABLE & ~empty_vec & ~stop_vec;

   // First eligible FIFO starting at the rotation pointer, wrapping modulo 4.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int i = 0; i < 4; i++) begin
         if (!found && eligible[ptr + 2'(i)]) begin
            found = 1'b1;
            pick  = ptr + 2'(i);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state          <= IDLE;
         ptr            <= 2'd0;
         sel            <= 2'd0;
         burst_cnt      <= 4'd0;
         bus.READ       <= 1'b0;
         bus.READ_FIFO  <= 2'd0;
         bus.DATA_OUT   <= 32'd0;
         bus.DATA_FIFO  <= 2'd0;
         bus.DATA_VALID <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  sel           <= pick;
                  bus.READ      <= 1'b1;
                  bus.READ_FIFO <= pick;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               bus.READ <= 1'b0;
               state    <= CAPTURE;
            end
            CAPTURE: begin
               bus.DATA_OUT   <= bus.IN;
               bus.DATA_FIFO  <= sel;
               bus.DATA_VALID <= 1'b1;
               burst_cnt      <= burst_cnt + 4'd1;
               state          <= HOLD;
            end
            HOLD: begin
               // Eligibility is taken on the accept cycle, so the pop from the last read is already visible.
               if (bus.DATA_READY) begin
                  bus.DATA_VALID <= 1'b0;
                  if (eligible[sel] && (burst_cnt < BURST_LIM)) begin
                     bus.READ      <= 1'b1;
                     bus.READ_FIFO <= sel;
                     state         <= ISSUE;
                  end else begin
                     ptr       <= sel + 2'd1;
                     burst_cnt <= 4'd0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // An acknowledge only masks CAREOF for one cycle when the marker is actually pending.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         pend   <= 4'd0;
         careof <= 4'd0;
      end else begin
         pend   <= bus.ENABLE & stop_vec;
         careof <= bus.ENABLE & ~(bus.INT_ACK & pend);
      end
   end

   assign bus.INT_PENDING  = pend;
   assign bus.CAREOF_INT_0 = careof[0];
   assign bus.CAREOF_INT_1 = careof[1];
   assign bus.CAREOF_INT_2 = careof[2];
   assign bus.CAREOF_INT_3 = careof[3];

endmodule

// File: tb/tb_lsab_drain.sv
// Bench for lsab_drain: LSAB FIFOs modelled as queues, an in-flight word scoreboard,
// table-driven burst-order scenarios, hand-written corner sequences and a random soak.
module tb_lsab_drain;

   localparam int BURST = 8;

   typedef struct packed {
      logic [3:0]       en;
      logic [3:0][7:0]  cnt;
      logic [3:0]       nruns;
      logic [11:0][7:0] runs;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   always #5 CLK = ~CLK;

   lsab_drain_if bus ();

   lsab_drain #(.BURST(BURST)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.master)
   );

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   bit          mon_on     = 1'b0;
   logic [31:0] fq [4][$];
   logic [33:0] inflight [$];
   int          rd_fifo [$];
   int          rd_cyc [$];
   logic [3:0]  exp_pend = '0;
   logic [3:0]  exp_care = '0;
   logic        p1_rd = 1'b0, p2_rd = 1'b0;
   logic [33:0] p1_w = '0, p2_w = '0;
   logic        prev_read = 1'b0, prev_hold = 1'b0;
   vec_t        tbl [6];

   task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] careof_vec();
      return {bus.CAREOF_INT_3, bus.CAREOF_INT_2, bus.CAREOF_INT_1, bus.CAREOF_INT_0};
   endfunction

   function automatic logic [3:0] stop_vec();
      return {bus.STOP_3, bus.STOP_2, bus.STOP_1, bus.STOP_0};
   endfunction

   task automatic sync_empty();
      bus.EMPTY_0 = (fq[0].size() == 0);
      bus.EMPTY_1 = (fq[1].size() == 0);
      bus.EMPTY_2 = (fq[2].size() == 0);
      bus.EMPTY_3 = (fq[3].size() == 0);
   endtask

   task automatic apply_stimulus(logic [3:0] en, logic [3:0] stp, logic rdy, logic [3:0] ack);
      bus.ENABLE = en;
      {bus.STOP_3, bus.STOP_2, bus.STOP_1, bus.STOP_0} = stp;
      bus.DATA_READY = rdy;
      bus.INT_ACK = ack;
   endtask

   task automatic load(int n, int count);
      for (int i = 0; i < count; i++) fq[n].push_back((32'(n) << 28) | 32'(i + 1));
   endtask

   // Per-cycle protocol rules, checked mid-cycle against the bench's own bookkeeping.
   task automatic monitor();
      check_output("int_pending", 64'(bus.INT_PENDING), 64'(exp_pend));
      check_output("careof_int", 64'(careof_vec()), 64'(exp_care));
      if (bus.READ) begin
         check_output("read_back_to_back", 64'(prev_read), 64'd0);
         check_output("read_one_in_flight", 64'(inflight.size()), 64'd0);
         check_output("read_fifo_nonempty", 64'(fq[bus.READ_FIFO].size() != 0), 64'd1);
      end
      if (p1_rd) check_output("capture_valid_low", 64'(bus.DATA_VALID), 64'd0);
      if (p2_rd) begin
         check_output("latency_valid", 64'(bus.DATA_VALID), 64'd1);
         check_output("latency_word", 64'({bus.DATA_FIFO, bus.DATA_OUT}), 64'(p2_w));
      end
      if (prev_hold) check_output("hold_valid", 64'(bus.DATA_VALID), 64'd1);
      if (bus.DATA_VALID) begin
         check_output("valid_has_word", 64'(inflight.size() != 0), 64'd1);
         if (inflight.size() != 0) begin
            check_output("data_word", 64'({bus.DATA_FIFO, bus.DATA_OUT}), 64'(inflight[0]));
            if (bus.DATA_READY) void'(inflight.pop_front());
         end
      end
   endtask

   task automatic step();
      logic        rd, rst_c;
      logic [1:0]  rf;
      logic [33:0] w;
      @(negedge CLK);
      rst_c = RST;
      rd    = bus.READ;
      rf    = bus.READ_FIFO;
      if (mon_on) monitor();
      if (!rst_c) begin
         exp_pend = '0;
         exp_care = '0;
      end else begin
         exp_care = bus.ENABLE & ~(bus.INT_ACK & exp_pend);
         exp_pend = bus.ENABLE & stop_vec();
      end
      prev_read = rd;
      prev_hold = bus.DATA_VALID & ~bus.DATA_READY;
      @(posedge CLK);
      #1;
      p2_rd = p1_rd;
      p2_w  = p1_w;
      p1_rd = 1'b0;
      if (rd && fq[rf].size() != 0) begin
         w = {rf, fq[rf].pop_front()};
         inflight.push_back(w);
         p1_rd  = 1'b1;
         p1_w   = w;
         bus.IN = w[31:0];
         rd_fifo.push_back(int'(rf));
         rd_cyc.push_back(cyc);
      end else begin
         bus.IN = $urandom;
      end
      if (!rst_c) begin
         p1_rd = 1'b0;
         p2_rd = 1'b0;
         prev_hold = 1'b0;
         prev_read = 1'b0;
         inflight.delete();
      end
      sync_empty();
      cyc++;
   endtask

   task automatic check_reset_outputs(string tag);
      check_output({tag, "_read"}, 64'(bus.READ), 64'd0);
      check_output({tag, "_read_fifo"}, 64'(bus.READ_FIFO), 64'd0);
      check_output({tag, "_data_valid"}, 64'(bus.DATA_VALID), 64'd0);
      check_output({tag, "_data_out"}, 64'(bus.DATA_OUT), 64'd0);
      check_output({tag, "_data_fifo"}, 64'(bus.DATA_FIFO), 64'd0);
      check_output({tag, "_int_pending"}, 64'(bus.INT_PENDING), 64'd0);
      check_output({tag, "_careof"}, 64'(careof_vec()), 64'd0);
   endtask

   task automatic do_reset();
      for (int n = 0; n < 4; n++) fq[n].delete();
      rd_fifo.delete();
      rd_cyc.delete();
      sync_empty();
      RST = 1'b0;
      step();
      RST = 1'b1;
      mon_on = 1'b1;
      check_reset_outputs("reset");
   endtask

   function automatic vec_t add_run(vec_t v, int f, int len);
      v.runs[v.nruns] = {2'(f), 6'(len)};
      v.nruns = v.nruns + 4'd1;
      return v;
   endfunction

   task automatic init_table();
      vec_t v;
      v = '0; v.en = 4'hF; v.cnt[2] = 8'd3;
      v = add_run(v, 2, 3);
      tbl[0] = v;
      v = '0; v.en = 4'hF;
      for (int n = 0; n < 4; n++) v.cnt[n] = 8'd20;
      for (int r = 0; r < 3; r++)
         for (int f = 0; f < 4; f++) v = add_run(v, f, (r == 2) ? 4 : BURST);
      tbl[1] = v;
      v = '0; v.en = 4'b0101;
      for (int n = 0; n < 4; n++) v.cnt[n] = 8'd10;
      v = add_run(v, 0, 8); v = add_run(v, 2, 8); v = add_run(v, 0, 2); v = add_run(v, 2, 2);
      tbl[2] = v;
      v = '0; v.en = 4'b1000; v.cnt[0] = 8'd3; v.cnt[3] = 8'd9;
      v = add_run(v, 3, 8); v = add_run(v, 3, 1);
      tbl[3] = v;
      v = '0; v.en = 4'hF; v.cnt[0] = 8'd1; v.cnt[1] = 8'd2; v.cnt[3] = 8'd1;
      v = add_run(v, 0, 1); v = add_run(v, 1, 2); v = add_run(v, 3, 1);
      tbl[4] = v;
      v = '0; v.en = 4'h0;
      for (int n = 0; n < 4; n++) v.cnt[n] = 8'd5;
      tbl[5] = v;
   endtask

   // Reads separated by more than three cycles, or from another FIFO, start a new burst.
   task automatic run_table();
      int rfs [$];
      int rls [$];
      int total;
      for (int t = 0; t < 6; t++) begin
         $display("[TB] table scenario %0d", t);
         do_reset();
         apply_stimulus(tbl[t].en, 4'h0, 1'b1, 4'h0);
         for (int n = 0; n < 4; n++) load(n, int'(tbl[t].cnt[n]));
         sync_empty();
         total = 0;
         for (int k = 0; k < int'(tbl[t].nruns); k++) total += int'(tbl[t].runs[k][5:0]);
         for (int c = 0; c < 700 && !(rd_fifo.size() >= total && inflight.size() == 0); c++) step();
         repeat (30) step();
         check_output("table_read_count", 64'(rd_fifo.size()), 64'(total));
         rfs.delete();
         rls.delete();
         for (int i = 0; i < rd_fifo.size(); i++) begin
            if (i == 0 || rd_fifo[i] != rd_fifo[i-1] || rd_cyc[i] - rd_cyc[i-1] > 3) begin
               rfs.push_back(rd_fifo[i]);
               rls.push_back(1);
            end else begin
               rls[rls.size()-1] = rls[rls.size()-1] + 1;
            end
         end
         check_output("table_run_count", 64'(rls.size()), 64'(tbl[t].nruns));
         for (int k = 0; k < int'(tbl[t].nruns) && k < rls.size(); k++)
            check_output("table_run", 64'({2'(rfs[k]), 6'(rls[k])}), 64'(tbl[t].runs[k]));
      end
   endtask

   task automatic seq_stall();
      $display("[TB] stall sequence");
      do_reset();
      apply_stimulus(4'hF, 4'h0, 1'b0, 4'h0);
      load(0, 2);
      sync_empty();
      for (int i = 0; i < 10 && !bus.DATA_VALID; i++) step();
      check_output("stall_valid_seen", 64'(bus.DATA_VALID), 64'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         check_output("stall_data_out", 64'(bus.DATA_OUT), 64'h00000001);
         check_output("stall_read_low", 64'(bus.READ), 64'd0);
      end
      bus.DATA_READY = 1'b1;
      step();
      check_output("stall_next_read", 64'({bus.READ, bus.READ_FIFO}), 64'({1'b1, 2'd0}));
      repeat (8) step();
      check_output("stall_drained", 64'(rd_fifo.size()), 64'd2);
   endtask

   task automatic seq_interrupt();
      int f1_reads;
      $display("[TB] interrupt marker sequence");
      do_reset();
      apply_stimulus(4'hF, 4'b0010, 1'b1, 4'h0);
      load(0, 2);
      load(1, 2);
      sync_empty();
      repeat (12) step();
      f1_reads = 0;
      foreach (rd_fifo[i]) if (rd_fifo[i] == 1) f1_reads++;
      check_output("stop_fifo1_skipped", 64'(f1_reads), 64'd0);
      check_output("stop_fifo0_drained", 64'(rd_fifo.size()), 64'd2);
      check_output("stop_pending", 64'(bus.INT_PENDING), 64'b0010);
      bus.INT_ACK = 4'b0100;
      step();
      bus.INT_ACK = 4'b0000;
      check_output("ack_ignored", 64'(careof_vec()), 64'hF);
      bus.INT_ACK = 4'b0010;
      step();
      bus.INT_ACK = 4'b0000;
      check_output("ack_careof_low", 64'(careof_vec()), 64'b1101);
      step();
      check_output("ack_careof_back", 64'(careof_vec()), 64'hF);
      {bus.STOP_3, bus.STOP_2, bus.STOP_1, bus.STOP_0} = 4'b0000;
      repeat (12) step();
      f1_reads = 0;
      foreach (rd_fifo[i]) if (rd_fifo[i] == 1) f1_reads++;
      check_output("stop_fifo1_resumed", 64'(f1_reads), 64'd2);
   endtask

   task automatic seq_reset_hold();
      $display("[TB] reset during hold sequence");
      do_reset();
      apply_stimulus(4'hF, 4'h0, 1'b1, 4'h0);
      load(1, 1);
      sync_empty();
      repeat (8) step();
      bus.DATA_READY = 1'b0;
      load(3, 2);
      load(0, 1);
      sync_empty();
      for (int i = 0; i < 10 && !bus.DATA_VALID; i++) step();
      check_output("hold_fifo3", 64'({bus.DATA_VALID, bus.DATA_FIFO, bus.DATA_OUT}),
                   64'({1'b1, 2'd3, 32'h30000001}));
      step();
      RST = 1'b0;
      check_output("reset_cycle_read", 64'(bus.READ), 64'd0);
      step();
      RST = 1'b1;
      check_reset_outputs("midhold");
      step();
      check_output("post_reset_read", 64'({bus.READ, bus.READ_FIFO}), 64'({1'b1, 2'd0}));
      bus.DATA_READY = 1'b1;
      repeat (12) step();
      check_output("post_reset_drained", 64'(fq[0].size() + fq[3].size()), 64'd0);
   endtask

   task automatic run_random();
      logic [3:0] en_r, stop_r, ack_r;
      int         n;
      $display("[TB] random soak");
      do_reset();
      en_r   = 4'hF;
      stop_r = 4'h0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) en_r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) stop_r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         ack_r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         apply_stimulus(en_r, stop_r, $urandom_range(0, 3) != 0, ack_r);
         if ($urandom_range(0, 2) == 0) begin
            n = int'($urandom_range(0, 3));
            if (fq[n].size() < 24) fq[n].push_back($urandom);
         end
         sync_empty();
         step();
      end
      apply_stimulus(4'hF, 4'h0, 1'b1, 4'h0);
      for (int c = 0; c < 1500 && (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()
                                   + inflight.size()) != 0; c++) step();
      repeat (5) step();
      for (int k = 0; k < 4; k++) check_output("random_fifo_drained", 64'(fq[k].size()), 64'd0);
      check_output("random_inflight_done", 64'(inflight.size()), 64'd0);
   endtask

   initial begin
      bus.IN = 32'd0;
      apply_stimulus(4'h0, 4'h0, 1'b0, 4'h0);
      sync_empty();
      init_table();
      run_table();
      seq_stall();
      seq_interrupt();
      seq_reset_hold();
      run_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
